// File: rtl/chameleon_serout_shiftreg_pkg.sv
// chameleon_serout_pkg: shared FSM encoding and counter-width helper for the serial-out chain driver.
package chameleon_serout_pkg;

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_LATCH, S_GAP} state_e;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chameleon_serout_shiftreg_if.sv
// chameleon_serout_shiftreg_if: parallel word in, 595-style serial chain and frame status out.
interface chameleon_serout_shiftreg_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] d;
    logic             refresh;
    logic             ser_out_clk;
    logic             ser_out_dat;
    logic             ser_out_rclk;
    logic             busy;
    logic             frame_done;
    modport master (output d, refresh, input ser_out_clk, ser_out_dat, ser_out_rclk, busy, frame_done);
    modport slave (input d, refresh, output ser_out_clk, ser_out_dat, ser_out_rclk, busy, frame_done);
endinterface

// File: rtl/chameleon_serout_shiftreg_tick_div.sv
// serout_tick_div: pulses tick every DIV cycles; restart holds the count at its first cycle.
module serout_tick_div
    import chameleon_serout_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = cw(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = cnt_q == CW'(DIV - 1);
        cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/chameleon_serout_shiftreg.sv
// chameleon_serout_shiftreg: snapshots d, shifts it out to a 595 chain, pulses rclk, repeats.
// Define SEROUT_CHANGE_ONLY_EN to start frames only on a changed word, refresh or first frame.
module chameleon_serout_shiftreg
    import chameleon_serout_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1
) (
    input logic clk,
    input logic reset,
    chameleon_serout_shiftreg_if.slave bus
);
    localparam int BW = cw(WIDTH);
    localparam int GW = cw(GAP);
    state_e           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d, idx;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             phase_q, phase_d, done_q, done_d, tick, start;

    serout_tick_div #(.DIV(DIV)) u_div (
        .clk     (clk),
        .rst     (reset),
        .restart (state_q != S_SHIFT && state_q != S_LATCH),
        .tick    (tick)
    );

`ifdef SEROUT_CHANGE_ONLY_EN
    logic [WIDTH-1:0] latched_q, latched_d;
    logic             valid_q, valid_d, pend_q, pend_d;
    assign start = !valid_q || pend_q || bus.refresh || bus.d != latched_q;
    always_comb begin
        latched_d = (state_q == S_LATCH && tick) ? shadow_q : latched_q;
        valid_d   = valid_q || (state_q == S_LATCH && tick);
        pend_d    = (state_q == S_IDLE && start) ? 1'b0 : pend_q || bus.refresh;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            latched_q <= '0;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            latched_q <= latched_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
        end
    end
`else
    logic unused_refresh;
    assign unused_refresh = bus.refresh;
    assign start = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            gap_q    <= '0;
            shadow_q <= '0;
            phase_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
        end
    end

    // Each bit is a low half (new data) then a high half; the last high half leaves the bit held for LATCH.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        phase_d  = phase_q;
        done_d   = state_q == S_LATCH && tick;
        case (state_q)
            S_IDLE:    state_d = start ? S_CAPTURE : S_IDLE;
            S_CAPTURE: begin
                state_d  = S_SHIFT;
                shadow_d = bus.d;
                bit_d    = '0;
                phase_d  = 1'b0;
            end
            S_SHIFT: if (tick) begin
                phase_d = !phase_q;
                if (phase_q && bit_q == BW'(WIDTH - 1)) state_d = S_LATCH;
                else if (phase_q) bit_d = bit_q + 1'b1;
            end
            S_LATCH: if (tick) begin
                state_d = (GAP > 0) ? S_GAP : S_IDLE;
                gap_d   = '0;
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP > 0 ? GAP - 1 : 0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx              = MSB_FIRST ? BW'(WIDTH - 1) - bit_q : bit_q;
        bus.ser_out_clk  = state_q == S_SHIFT && phase_q;
        bus.ser_out_dat  = (state_q == S_SHIFT || state_q == S_LATCH) && shadow_q[idx];
        bus.ser_out_rclk = state_q == S_LATCH;
        bus.busy         = state_q != S_IDLE;
        bus.frame_done   = done_q;
    end
endmodule
